// File: rtl/framebuffer_arbiter.sv
// -----------------------------------------------------------------------------
// framebuffer_arbiter
//
// Schedules the single-port frame-buffer RAM between three users:
//   1. VGA pixel fetch (strict priority, one read per cycle, 2-cycle latency)
//   2. internal screen-clear engine (fills every pixel with a latched colour)
//   3. external drawing engine (valid/ready writer, out-of-range writes dropped)
//
// Optional feature: define FB_STATS_EN to build the write-stall counter.
// Without it, stall_count is tied to zero and no counter logic exists.
//
// Ports:
//   Clk, Reset          system clock, synchronous active-high reset
//   rd_req, rd_addr     VGA fetch request / address (not range-checked)
//   rd_data, rd_valid   fetched colour index, valid two cycles after rd_req
//   wr_valid, wr_ready  writer handshake (transfer when both high)
//   wr_addr, wr_data    writer address / colour index
//   wr_err              one-cycle pulse after an accepted out-of-range write
//   clear_start         pulse: begin (or restart) a full-screen fill
//   clear_color         fill colour, sampled on clear_start
//   clear_busy          fill in progress
//   mem_addr, mem_we,
//   mem_wdata           RAM address / write enable / write data
//   mem_rdata           RAM read data (1-cycle synchronous read)
//   stall_count         cycles a writer waited (saturating, FB_STATS_EN only)
// -----------------------------------------------------------------------------
module framebuffer_arbiter #(
    parameter int X_SIZE = 640,
    parameter int Y_SIZE = 480,
    parameter int AW     = 19,
    parameter int DW     = 8
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          rd_req,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic          wr_err,
    input  logic          clear_start,
    input  logic [DW-1:0] clear_color,
    output logic          clear_busy,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [15:0]   stall_count
);

    localparam int unsigned   NPIX     = X_SIZE * Y_SIZE;
    localparam logic [AW-1:0] PIX_END  = AW'(NPIX);
    localparam logic [AW-1:0] PIX_LAST = AW'(NPIX - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [AW-1:0] r_clr_cnt;
    logic [AW-1:0] w_clr_cnt_next;
    logic [DW-1:0] r_clr_color;
    logic [DW-1:0] w_clr_color_next;

    logic [AW-1:0] r_last_addr;
    logic          r_rd_pend;
    logic          r_rd_valid;
    logic [DW-1:0] r_rd_data;
    logic          r_wr_err;

    logic          w_grant_clr;
    logic          w_grant_wr;
    logic          w_wr_in_range;
    logic [AW-1:0] w_mem_addr;
    logic          w_mem_we;
    logic [DW-1:0] w_mem_wdata;

    // ------------------------------------------------------------------
    // Fixed-priority grant: VGA read, then clear engine, then writer.
    // No RAM write or writer handshake completes while Reset is held, so a
    // fill interrupted by reset leaves the remaining pixels untouched.
    // ------------------------------------------------------------------
    assign w_grant_clr   = !rd_req && (r_state == CLEAR) && !Reset;
    assign w_grant_wr    = !rd_req && (r_state == IDLE) && wr_valid && !Reset;
    assign w_wr_in_range = (wr_addr < PIX_END);

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // through the if/else chain can leave it unassigned and infer a latch.
        w_mem_addr  = r_last_addr;
        w_mem_we    = 1'b0;
        w_mem_wdata = '0;
        if (rd_req) begin
            w_mem_addr = rd_addr;
        end else if (w_grant_clr) begin
            w_mem_addr  = r_clr_cnt;
            w_mem_we    = 1'b1;
            w_mem_wdata = r_clr_color;
        end else if (w_grant_wr) begin
            w_mem_addr  = wr_addr;
            w_mem_we    = w_wr_in_range;
            w_mem_wdata = wr_data;
        end
    end

    // ------------------------------------------------------------------
    // Clear FSM next state. clear_start overrides everything, including the
    // final fill slot, so a restart always begins again from pixel 0.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next     = r_state;
        w_clr_cnt_next   = r_clr_cnt;
        w_clr_color_next = r_clr_color;
        if (w_grant_clr) begin
            if (r_clr_cnt == PIX_LAST) begin
                w_state_next   = IDLE;
                w_clr_cnt_next = '0;
            end else begin
                w_clr_cnt_next = r_clr_cnt + AW'(1);
            end
        end
        if (clear_start) begin
            w_state_next     = CLEAR;
            w_clr_cnt_next   = '0;
            w_clr_color_next = clear_color;
        end
    end

    always_ff @(posedge Clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (Reset) begin
            r_state     <= IDLE;
            r_clr_cnt   <= '0;
            r_clr_color <= '0;
            r_last_addr <= '0;
            r_rd_pend   <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_rd_data   <= '0;
            r_wr_err    <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_clr_cnt   <= w_clr_cnt_next;
            r_clr_color <= w_clr_color_next;
            r_last_addr <= w_mem_addr;
            // Read pipeline: address goes out in cycle N, RAM data appears in
            // N+1 and is registered so rd_data/rd_valid are seen in N+2.
            r_rd_pend   <= rd_req;
            r_rd_valid  <= r_rd_pend;
            if (r_rd_pend) begin
                r_rd_data <= mem_rdata;
            end
            r_wr_err    <= w_grant_wr && !w_wr_in_range;
        end
    end

    assign mem_addr   = w_mem_addr;
    assign mem_we     = w_mem_we;
    assign mem_wdata  = w_mem_wdata;
    assign wr_ready   = w_grant_wr;
    assign wr_err     = r_wr_err;
    assign rd_valid   = r_rd_valid;
    assign rd_data    = r_rd_data;
    assign clear_busy = (r_state == CLEAR);

`ifdef FB_STATS_EN
    logic [15:0] r_stall_count;

    always_ff @(posedge Clk) begin
        if (Reset || clear_start) begin
            r_stall_count <= '0;
        end else if (wr_valid && !w_grant_wr && (r_stall_count != 16'hFFFF)) begin
            r_stall_count <= r_stall_count + 16'd1;
        end
    end

    assign stall_count = r_stall_count;
`else
    assign stall_count = 16'd0;
`endif

endmodule

// File: tb/tb_framebuffer_arbiter.sv
`timescale 1ns/1ps
module tb_framebuffer_arbiter;

    // Small screen so a full fill fits in a short run; same arithmetic rules.
    localparam int X_SIZE = 16;
    localparam int Y_SIZE = 12;
    localparam int AW     = 8;
    localparam int DW     = 8;
    localparam int NPIX   = X_SIZE * Y_SIZE;
    localparam int DEPTH  = 1 << AW;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_err;
    logic          clear_start;
    logic [DW-1:0] clear_color;
    logic          clear_busy;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic [15:0]   stall_count;

    always #5 Clk = ~Clk;

    framebuffer_arbiter #(
        .X_SIZE(X_SIZE), .Y_SIZE(Y_SIZE), .AW(AW), .DW(DW)
    ) dut (
        .Clk(Clk), .Reset(Reset),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_err(wr_err),
        .clear_start(clear_start), .clear_color(clear_color), .clear_busy(clear_busy),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .stall_count(stall_count)
    );

    // Physical frame-buffer RAM, 1-cycle synchronous read.
    logic [DW-1:0] ram [DEPTH];
    always @(posedge Clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    // Reference model: what the frame buffer should contain, plus the clear
    // job described as "pixels still to fill", and the expected statistics.
    logic [DW-1:0] ref_mem [DEPTH];
    bit            ref_clr;
    int            ref_clr_idx;
    logic [DW-1:0] ref_clr_col;
    int            ref_last;
    int            ref_stall;
    bit            ref_accept;

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } rd_exp_t;

    rd_exp_t rd_q[$];
    int      err_q[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit mon_en = 1'b0;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // One clock cycle: inputs are already applied; at the falling edge the
    // combinational grant and registered status are compared with the model,
    // then the model commits this cycle's effects.
    task automatic step();
        bit            exp_ready;
        bit            exp_we;
        int            exp_addr;
        logic [DW-1:0] exp_wdata;
        rd_exp_t       e;
        @(negedge Clk);
        ref_accept = 1'b0;
        if (Reset) begin
            ref_clr     = 1'b0;
            ref_clr_idx = 0;
            ref_clr_col = '0;
            ref_last    = 0;
            ref_stall   = 0;
            rd_q.delete();
            err_q.delete();
        end else begin
            exp_ready = wr_valid && !rd_req && !ref_clr;
            exp_we    = 1'b0;
            exp_wdata = '0;
            exp_addr  = ref_last;
            if (rd_req) begin
                exp_addr = int'(rd_addr);
            end else if (ref_clr) begin
                exp_addr  = ref_clr_idx;
                exp_we    = 1'b1;
                exp_wdata = ref_clr_col;
            end else if (wr_valid) begin
                exp_addr  = int'(wr_addr);
                exp_we    = (int'(wr_addr) < NPIX);
                exp_wdata = wr_data;
            end
            check("wr_ready", wr_ready, exp_ready);
            check("mem_we", mem_we, exp_we);
            check("mem_addr", mem_addr, exp_addr);
            if (exp_we) check("mem_wdata", mem_wdata, exp_wdata);
            check("clear_busy", clear_busy, ref_clr);
`ifdef FB_STATS_EN
            check("stall_count", stall_count, ref_stall);
`else
            check("stall_count_tied", stall_count, 0);
`endif
            if (rd_req) begin
                e.data = ref_mem[rd_addr];
                e.due  = cyc + 2;
                rd_q.push_back(e);
            end
            if (exp_we) ref_mem[exp_addr] = exp_wdata;
            if (ref_clr && !rd_req) begin
                if (ref_clr_idx == NPIX - 1) begin
                    ref_clr     = 1'b0;
                    ref_clr_idx = 0;
                end else begin
                    ref_clr_idx++;
                end
            end
            if (exp_ready && !(int'(wr_addr) < NPIX)) err_q.push_back(cyc + 1);
            ref_accept = exp_ready;
            if (clear_start) ref_stall = 0;
            else if (wr_valid && !exp_ready && ref_stall < 65535) ref_stall++;
            if (clear_start) begin
                ref_clr     = 1'b1;
                ref_clr_idx = 0;
                ref_clr_col = clear_color;
            end
            ref_last = exp_addr;
        end
        @(posedge Clk);
        #1;
    endtask

    // Monitor: pops expected read data / error pulses when the DUT presents them.
    always @(negedge Clk) begin
        rd_exp_t e;
        int      due;
        if (mon_en && !Reset) begin
            if (rd_valid) begin
                if (rd_q.size() == 0) begin
                    check("rd_valid_spurious", rd_valid, 1'b0);
                end else begin
                    e = rd_q.pop_front();
                    check("rd_valid_cycle", cyc, e.due);
                    check("rd_data", rd_data, e.data);
                end
            end else if (rd_q.size() != 0 && rd_q[0].due <= cyc) begin
                e = rd_q.pop_front();
                check("rd_valid_missing", rd_valid, 1'b1);
            end
            if (wr_err) begin
                if (err_q.size() == 0) begin
                    check("wr_err_spurious", wr_err, 1'b0);
                end else begin
                    due = err_q.pop_front();
                    check("wr_err_cycle", cyc, due);
                end
            end else if (err_q.size() != 0 && err_q[0] <= cyc) begin
                due = err_q.pop_front();
                check("wr_err_missing", wr_err, 1'b1);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] v;
        logic [DW-1:0] old150;
        int            busy_cycles;
        int            nbad;
        bit            wr_pending;

        Reset       = 1'b1;
        rd_req      = 1'b0;
        rd_addr     = '0;
        wr_valid    = 1'b0;
        wr_addr     = '0;
        wr_data     = '0;
        clear_start = 1'b0;
        clear_color = '0;
        for (int i = 0; i < DEPTH; i++) begin
            v          = (i == 100) ? 8'h3C : DW'($urandom);
            ram[i]     <= v;
            ref_mem[i] = v;
        end

        // Reset state
        step();
        step();
        check("reset_rd_valid", rd_valid, 1'b0);
        check("reset_rd_data", rd_data, 0);
        check("reset_wr_err", wr_err, 1'b0);
        check("reset_clear_busy", clear_busy, 1'b0);
        check("reset_stall_count", stall_count, 0);
        Reset  = 1'b0;
        mon_en = 1'b1;

        // Read latency: RAM[100]=3C returned two cycles later
        rd_req = 1'b1; rd_addr = 8'd100;
        step();
        rd_req = 1'b0;
        repeat (3) step();

        // Read has priority over the writer
        rd_req = 1'b1; rd_addr = 8'd3;
        wr_valid = 1'b1; wr_addr = 8'd150; wr_data = 8'h11;
        step();
        rd_req = 1'b0;
        step();
        wr_valid = 1'b0;
        step();
        check("ram150_written", ram[150], 8'h11);

        // Out-of-range write: accepted, dropped, wr_err next cycle
        wr_valid = 1'b1; wr_addr = AW'(NPIX); wr_data = 8'hAA;
        step();
        wr_valid = 1'b0;
        repeat (2) step();
        check("oor_ram_unchanged", ram[NPIX], ref_mem[NPIX]);

        // Full clear with reads every other cycle and a waiting writer
        wr_valid = 1'b1; wr_addr = 8'd10; wr_data = 8'h77;
        clear_color = 8'h05; clear_start = 1'b1;
        step();
        clear_start = 1'b0;
        busy_cycles = 0;
        for (int i = 0; i < 4 * NPIX; i++) begin
            if (!clear_busy) break;
            busy_cycles++;
            rd_req  = (i % 2 == 0);
            rd_addr = AW'($urandom_range(0, NPIX - 1));
            step();
        end
        check("clear_busy_cycles",
              (busy_cycles >= 2 * NPIX - 2 && busy_cycles <= 2 * NPIX + 2) ? 2 * NPIX : busy_cycles,
              2 * NPIX);
        nbad = 0;
        for (int i = 0; i < NPIX; i++) if (ram[i] !== 8'h05) nbad++;
        check("clear_fill_bad_pixels", nbad, 0);
        rd_req = 1'b0;
        step();
        wr_valid = 1'b0;
        repeat (3) step();

        // Reset in the middle of a clear
        old150 = ram[150];
        clear_color = old150 ^ 8'hFF; clear_start = 1'b1;
        step();
        clear_start = 1'b0;
        repeat (100) step();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        check("busy_after_reset", clear_busy, 1'b0);
        step();
        check("reset_clear_keeps_ram150", ram[150], old150);
        wr_valid = 1'b1; wr_addr = 8'd40; wr_data = 8'h5A;
        step();
        wr_valid = 1'b0;
        step();
        check("post_reset_write", ram[40], 8'h5A);

        // Stall statistic: writer waits behind 10 reads, then clear_start
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        rd_req = 1'b1; rd_addr = 8'd1;
        wr_valid = 1'b1; wr_addr = 8'd41; wr_data = 8'h01;
        repeat (10) step();
`ifdef FB_STATS_EN
        check("stall_after_10", stall_count, 10);
`else
        check("stall_after_10_tied", stall_count, 0);
`endif
        rd_req = 1'b0;
        step();
        wr_valid = 1'b0;
        clear_color = 8'h33; clear_start = 1'b1;
        step();
        clear_start = 1'b0;
        check("stall_cleared_by_start", stall_count, 0);

        // Randomized traffic
        wr_pending = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            rd_req  = ($urandom_range(0, 2) == 0);
            rd_addr = AW'($urandom_range(0, DEPTH - 1));
            if (!wr_pending) begin
                if ($urandom_range(0, 1) == 1) begin
                    wr_pending = 1'b1;
                    case ($urandom_range(0, 5))
                        0:       wr_addr = AW'(NPIX - 1);
                        1:       wr_addr = AW'(NPIX);
                        2:       wr_addr = AW'($urandom_range(NPIX, DEPTH - 1));
                        default: wr_addr = AW'($urandom_range(0, NPIX - 1));
                    endcase
                    wr_data = DW'($urandom);
                end
            end else if ($urandom_range(0, 9) == 0) begin
                wr_pending = 1'b0;
            end
            wr_valid    = wr_pending;
            clear_start = ($urandom_range(0, 399) == 0);
            clear_color = DW'($urandom);
            step();
            if (ref_accept) wr_pending = 1'b0;
        end

        // Drain and compare
        rd_req = 1'b0; wr_valid = 1'b0; clear_start = 1'b0;
        repeat (2 * NPIX + 10) step();
        check("rd_queue_drained", rd_q.size(), 0);
        check("err_queue_drained", err_q.size(), 0);
        nbad = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ram[i] !== ref_mem[i]) begin
                nbad++;
                if (nbad <= 4) $display("  ram[%0d] = 0x%0h, model 0x%0h", i, ram[i], ref_mem[i]);
            end
        end
        check("ram_contents_bad_words", nbad, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/framebuffer_arbiter.md
Name: framebuffer_arbiter

Overview:
- Schedules the single-port frame-buffer RAM between three users:
  - the VGA pixel-fetch path, which issues addresses of the form x + y*X_SIZE;
  - an external drawing engine (writer);
  - an internal screen-clear engine.
- VGA reads have strict priority so the colour palette path never starves. Free slots are given to the clear engine first, then to the writer.
- Sits between the VGA/colour-mapping logic, the drawing logic and the frame-buffer RAM.

Parameters:
- X_SIZE, 640, pixels per line.
- Y_SIZE, 480, lines per frame.
- AW, 19, address width.
- DW, 8, colour-index width.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- rd_req  in  1  VGA fetch request, one cycle per pixel.
- rd_addr  in  AW  VGA fetch address.
- rd_data  out  DW  fetched colour index.
- rd_valid  out  1  rd_data valid strobe.
- wr_valid  in  1  writer request.
- wr_ready  out  1  writer accepted this cycle.
- wr_addr  in  AW  writer address.
- wr_data  in  DW  writer colour index.
- wr_err  out  1  pulse: accepted write was out of range and dropped.
- clear_start  in  1  pulse: begin full-screen fill.
- clear_color  in  DW  fill colour, sampled on clear_start.
- clear_busy  out  1  fill in progress.
- mem_addr  out  AW  RAM address.
- mem_we  out  1  RAM write enable.
- mem_wdata  out  DW  RAM write data.
- mem_rdata  in  DW  RAM read data, 1-cycle synchronous read.
- stall_count  out  16  write-stall statistic (see Optional Feature).

Behaviour:
- **Reset values.** Reset is synchronous and active-high. At reset:
  - rd_valid=0, rd_data=0, wr_err=0;
  - clear_busy=0, FSM=IDLE, clear counter=0, latched colour=0;
  - stall_count=0.
- **Grant per cycle.** Combinational, fixed priority:
  1. rd_req: mem_addr=rd_addr, mem_we=0.
  2. Else if FSM=CLEAR: mem_addr=clr_cnt, mem_we=1, mem_wdata=latched colour; clr_cnt increments.
  3. Else if wr_valid: wr_ready=1, mem_addr=wr_addr, mem_we=(wr_addr<X_SIZE*Y_SIZE), mem_wdata=wr_data.
  4. Else: mem_we=0, mem_addr holds its last registered value.
- **wr_ready** is 1 only under condition 3 above. It is 0 whenever rd_req=1 or clear_busy=1.
- **Writer handshake.** A transfer occurs iff wr_valid && wr_ready.
  - The writer must hold wr_addr and wr_data stable until that cycle.
  - Dropping wr_valid before acceptance is legal (the request is withdrawn).
- **Out-of-range writes.** If an accepted write has wr_addr >= X_SIZE*Y_SIZE:
  - no RAM write occurs;
  - wr_err pulses high for 1 cycle, on the cycle after acceptance.
- **Read latency.** rd_req sampled in cycle N gives rd_valid=1 and rd_data=mem_rdata registered in cycle N+2.
  - Back-to-back rd_req is supported, one result per cycle in order.
  - rd_addr is not range-checked.
- **Clear FSM.**
  - IDLE → CLEAR on clear_start: latch clear_color, clr_cnt=0, clear_busy=1.
  - CLEAR → IDLE on the write slot where clr_cnt=X_SIZE*Y_SIZE-1. clear_busy drops the following cycle.
  - clear_start while in CLEAR: restart, i.e. counter back to 0 and the new colour latched.
  - clear_start in the same cycle as rd_req: the start is still accepted; the first fill write waits for a free slot.
- **Reset mid-clear.** FSM goes to IDLE and remaining pixels are left unwritten. Reset mid-read: any pending rd_valid is discarded.
- **Arithmetic.** clr_cnt is AW bits wide. The X_SIZE*Y_SIZE comparison is made at AW bits (307200 < 2^19).

Optional Feature:
- Macro: FB_STATS_EN.
- **Defined:** stall_count increments each cycle with wr_valid && !wr_ready.
  - It saturates at 16'hFFFF.
  - It clears on Reset and on clear_start.
- **Undefined:** stall_count is tied to 0 and no counter logic is synthesized.

Test Plan:
- **Read latency.** rd_req with rd_addr=100 at cycle 5, RAM preloaded [100]=8'h3C → rd_valid=1, rd_data=8'h3C at cycle 7; mem_we=0 at cycle 5.
- **Read priority over writer.** rd_req and wr_valid both high (wr_addr=200, wr_data=8'h11) → wr_ready=0 that cycle. Next cycle with rd_req=0 → wr_ready=1, mem_we=1, RAM[200]=8'h11.
- **Out-of-range write.** wr_valid with wr_addr=307200 → wr_ready=1, mem_we=0, wr_err=1 next cycle; RAM unchanged.
- **Clear with interleaved reads.** clear_start with clear_color=8'h05, rd_req asserted every other cycle → clear_busy high for 614400 cycles ±2. All RAM[0..307199]=8'h05, wr_ready=0 throughout, reads still return data at N+2.
- **Reset mid-clear.** Reset at clr_cnt≈1000 → clear_busy=0 next cycle, RAM[2000] keeps its old value, subsequent writer traffic is accepted.
- **Stall statistic (FB_STATS_EN).** wr_valid held through 10 rd_req cycles → stall_count=10; clear_start → stall_count=0.
